// File: rtl/branch_predictor_tournament.sv
// branch_predictor_tournament: local/gshare/tournament direction predictor with a direct-mapped tagged BTB.
// Predicts combinationally in IF; trains non-speculatively from EX resolution.
module branch_predictor_tournament #(
   parameter int BHR_SIZE = 5,
   parameter int LOC_IDX  = 5,
   parameter int BTB_IDX  = 4,
   parameter int MODE     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         pc_if,
   input  logic [6:0]          opcode_if,
   output logic                is_branch_if,
   output logic                is_jump_if,
   output logic                predict_taken,
   output logic                loc_predict_taken_if,
   output logic                glob_predict_taken_if,
   output logic [BHR_SIZE-1:0] bhr_if,
   output logic                use_predicted,
   output logic [31:0]         predicted_pc,
   input  logic                resolve_valid,
   input  logic                is_branch_ex,
   input  logic                is_jump_ex,
   input  logic [31:0]         pc_ex,
   input  logic [31:0]         branch_pc_ex,
   input  logic                cmp_out_ex,
   input  logic [BHR_SIZE-1:0] bhr_ex,
   input  logic                loc_predict_taken_ex,
   input  logic                glob_predict_taken_ex
);
   localparam int TAG_W = 30 - BTB_IDX;
   logic [1:0]          loc_pht_q  [2**LOC_IDX];
   logic [1:0]          cho_q      [2**LOC_IDX];
   logic [1:0]          glob_pht_q [2**BHR_SIZE];
   logic [BHR_SIZE-1:0] bhr_q, bhr_d;
   logic [2**BTB_IDX-1:0] btb_valid_q;
   logic [TAG_W-1:0]    btb_tag_q  [2**BTB_IDX];
   logic [31:0]         btb_tgt_q  [2**BTB_IDX];
   logic [LOC_IDX-1:0]  li_if, li_ex;
   logic [BHR_SIZE-1:0] gi_if, gi_ex;
   logic [BTB_IDX-1:0]  bi_if, bi_ex;
   logic [BHR_SIZE:0]   bhr_sh;
   logic [1:0]          loc_d, glob_d, cho_d;
   logic                dir, btb_hit, taken_ex, br_upd, btb_upd, cho_upd, unused_ok;

   function automatic logic [1:0] sat(input logic [1:0] c, input logic up);
      return up ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
   endfunction

   always_comb begin
      li_if                 = pc_if[LOC_IDX+1:2];
      gi_if                 = bhr_q ^ pc_if[BHR_SIZE+1:2];
      bi_if                 = pc_if[BTB_IDX+1:2];
      li_ex                 = pc_ex[LOC_IDX+1:2];
      gi_ex                 = bhr_ex ^ pc_ex[BHR_SIZE+1:2];
      bi_ex                 = pc_ex[BTB_IDX+1:2];
      is_branch_if          = opcode_if == 7'b1100011;
      is_jump_if            = opcode_if == 7'b1101111 || opcode_if == 7'b1100111;
      loc_predict_taken_if  = loc_pht_q[li_if][1];
      glob_predict_taken_if = glob_pht_q[gi_if][1];
      dir                   = (MODE == 0) ? loc_predict_taken_if :
                              (MODE == 1) ? glob_predict_taken_if :
                              (cho_q[li_if][1] ? glob_predict_taken_if : loc_predict_taken_if);
      predict_taken         = is_jump_if | (is_branch_if & dir);
      btb_hit               = btb_valid_q[bi_if] && btb_tag_q[bi_if] == pc_if[31:BTB_IDX+2];
      use_predicted         = predict_taken & btb_hit;
      predicted_pc          = use_predicted ? btb_tgt_q[bi_if] : pc_if + 32'd4;
      bhr_if                = bhr_q;
      // gating with resolve_valid first keeps X on the EX qualifiers out of the state
      taken_ex              = is_jump_ex | (is_branch_ex & cmp_out_ex);
      br_upd                = resolve_valid & is_branch_ex;
      btb_upd               = resolve_valid & taken_ex;
      cho_upd               = br_upd && MODE == 2 && loc_predict_taken_ex != glob_predict_taken_ex;
      loc_d                 = sat(loc_pht_q[li_ex], cmp_out_ex);
      glob_d                = sat(glob_pht_q[gi_ex], cmp_out_ex);
      cho_d                 = sat(cho_q[li_ex], glob_predict_taken_ex == cmp_out_ex);
      bhr_sh                = {bhr_q, cmp_out_ex};
      bhr_d                 = bhr_sh[BHR_SIZE-1:0];
      unused_ok             = ^{pc_if[1:0], pc_ex[1:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 2**LOC_IDX; i++) begin
            loc_pht_q[i] <= 2'b01;
            cho_q[i]     <= 2'b01;
         end
         for (int i = 0; i < 2**BHR_SIZE; i++) glob_pht_q[i] <= 2'b01;
         bhr_q       <= '0;
         btb_valid_q <= '0;
      end else begin
         if (br_upd) begin
            loc_pht_q[li_ex]  <= loc_d;
            glob_pht_q[gi_ex] <= glob_d;
            bhr_q             <= bhr_d;
         end
         if (cho_upd) cho_q[li_ex] <= cho_d;
         if (btb_upd) btb_valid_q[bi_ex] <= 1'b1;
      end
   end

   // tags and targets are qualified by the valid bits, so they need no reset
   always_ff @(posedge clk) begin
      if (btb_upd) begin
         btb_tag_q[bi_ex] <= pc_ex[31:BTB_IDX+2];
         btb_tgt_q[bi_ex] <= branch_pc_ex;
      end
   end
endmodule

// File: doc/branch_predictor_tournament.md
Name: branch_predictor_tournament

Overview:
Parametrised next-generation branch predictor for the 5-stage RV32I pipeline. It predicts in IF and is updated at branch resolution in EX. It combines a PC-indexed local PHT, a gshare global PHT and a per-PC chooser, selected by MODE, with a direct-mapped tagged BTB. It feeds the IF next-PC mux through use_predicted and predicted_pc. The pipeline carries bhr and per-component predictions from IF to EX for the update.

Parameters:
BHR_SIZE, 5, global history bits; global PHT depth is 2^BHR_SIZE (legal 1..12)
LOC_IDX, 5, local PHT and chooser index bits; depth is 2^LOC_IDX (legal 1..12)
BTB_IDX, 4, BTB index bits; 2^BTB_IDX entries (legal 1..10)
MODE, 2, 0=local only, 1=gshare only, 2=tournament

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
pc_if  in  32  PC of the instruction in IF
opcode_if  in  7  inst_rdata[6:0] in IF
is_branch_if  out  1  opcode_if==7'b1100011
is_jump_if  out  1  opcode_if is 7'b1101111 or 7'b1100111
predict_taken  out  1  final direction prediction
loc_predict_taken_if  out  1  local counter MSB
glob_predict_taken_if  out  1  global counter MSB
bhr_if  out  BHR_SIZE  current history register
use_predicted  out  1  redirect fetch to predicted_pc
predicted_pc  out  32  BTB target if use_predicted, else pc_if+4
resolve_valid  in  1  EX holds a resolving control instruction and EX is not stalled (one pulse per instruction)
is_branch_ex  in  1  EX instruction is a conditional branch
is_jump_ex  in  1  EX instruction is JAL or JALR
pc_ex  in  32  PC of the EX instruction
branch_pc_ex  in  32  resolved target address
cmp_out_ex  in  1  branch outcome (1 = taken)
bhr_ex  in  BHR_SIZE  bhr_if captured when this instruction was in IF
loc_predict_taken_ex  in  1  loc_predict_taken_if carried to EX
glob_predict_taken_ex  in  1  glob_predict_taken_if carried to EX

Behaviour:
- Prediction is purely combinational from pc_if, opcode_if and the state registers; zero-cycle latency.
- Local index: li = pc[LOC_IDX+1:2].
- Global index: gi = bhr ^ pc[BHR_SIZE+1:2].
- BTB index: pc[BTB_IDX+1:2]; tag pc[31:BTB_IDX+2].
- btb_hit = valid && tag match.
- Counters are 2-bit; MSB=1 means taken.
- Chooser MSB=1 selects global; it is used only when MODE=2.
- predict_taken is 1 for a jump; for a branch it is the counter MSB selected by MODE/chooser; otherwise 0.
- use_predicted = predict_taken & btb_hit. When use_predicted=0, predicted_pc = pc_if+4, with 32-bit wrap (0xFFFFFFFC gives 0).
- Reset (async, applied immediately):
  - all PHT counters = 2'b01; all chooser counters = 2'b01
  - bhr = 0; all BTB valid bits = 0 (tags and targets don't-care)
  - outputs then follow from the cleared state: use_predicted=0, and predict_taken=0 for branches.
- Update happens on a rising edge with resolve_valid=1. Define taken = is_jump_ex | (is_branch_ex & cmp_out_ex).
- For branches only:
  - Local counter at pc_ex index: saturating +1 if taken, else -1 (11 stays 11, 00 stays 00).
  - Global counter at bhr_ex ^ pc_ex[BHR_SIZE+1:2]: same saturating rule.
  - When MODE=2 and loc_predict_taken_ex != glob_predict_taken_ex: chooser at the pc_ex index +1 if the global prediction was correct, else -1, saturating.
  - Chooser is never written when MODE is 0 or 1.
  - bhr <= {bhr[BHR_SIZE-2:0], cmp_out_ex}. When BHR_SIZE=1, bhr <= cmp_out_ex.
- Jumps do not touch the PHTs, the chooser or bhr.
- BTB write occurs on every taken branch or jump: tag, target=branch_pc_ex, valid=1. It overwrites any alias (direct-mapped, no replacement policy). A not-taken branch does not write the BTB.
- History is non-speculative: bhr changes only at resolution. When resolve_valid=0, no state changes.
- Same-cycle read and write to the same entry: the IF lookup sees the pre-write value; the new value is visible the next cycle.
- The block has no stall input. The caller deasserts resolve_valid during stalls and squashed slots.
- X on is_branch_ex/is_jump_ex while resolve_valid=0 must not corrupt state.

Test Plan:
1. After reset, pc_if=0x40, opcode_if=0x63 -> is_branch_if=1, predict_taken=0, use_predicted=0, predicted_pc=0x44, bhr_if=0.
2. MODE=0: resolve a taken branch, pc_ex=0x40 target 0x80 -> next cycle with pc_if=0x40: predict_taken=1, use_predicted=1, predicted_pc=0x80, bhr_if=5'b00001.
3. MODE=0, at pc 0x40: 4 taken resolves then 1 not-taken -> still predict_taken=1; 2 more not-taken -> predict_taken=0, use_predicted=0, predicted_pc=0x44.
4. JAL at 0x100 with empty BTB -> predict_taken=1, use_predicted=0, predicted_pc=0x104; after resolve with target 0x200 -> use_predicted=1, predicted_pc=0x200, bhr unchanged.
5. BTB_IDX=4: taken branches at 0x40 then 0x440 (same index) -> lookup at 0x40 misses (use_predicted=0); a same-cycle resolve and lookup at 0x40 returns the old entry.
6. MODE=2, BHR_SIZE=5, alternating T/N at pc 0x40 for 32 resolves -> after warm-up, chooser MSB=1 and every prediction in the last 8 is correct; assert rst mid-run -> use_predicted=0 immediately, without waiting for a clock edge.
